// File: rtl/irq_enc_pkg.sv
// Shared definitions for the interrupt/select priority encoder:
// default sizing, index-width derivation, FSM states and the one-hot helper.
package irq_enc_pkg;

  localparam int N_IN_DEFAULT = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_w(N_IN_DEFAULT);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic logic [N_IN_DEFAULT-1:0] onehot(input logic [IDX_W_DEFAULT-1:0] idx);
    logic [N_IN_DEFAULT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_priority_encoder_prio_pick.sv
// Combinational pick of the first set bit, scanning upward from base_i
// with wrap when rot_i is set, or from bit 0 when it is clear.
module prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] base_i,
  input  logic         rot_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  int         pos_s;
  logic [W-1:0] sel_s;
  logic       hit_s;

  // Scan N positions in priority order; the first hit freezes the result.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos_s   = 0;
    sel_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_s   = rot_i ? (int'(base_i) + k) : k;
      pos_s   = (pos_s >= N) ? (pos_s - N) : pos_s;
      sel_s   = W'(pos_s);
      hit_s   = !found_o && vec_i[sel_s];
      idx_o   = hit_s ? sel_s : idx_o;
      found_o = found_o | hit_s;
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// Sequential priority encoder: latches request pulses into a pending set and
// streams one winning index at a time over a valid/ready handshake.
module irq_priority_encoder
  import irq_enc_pkg::*;
#(
  parameter int N_IN        = N_IN_DEFAULT,
  parameter int IDX_W       = idx_w(N_IN),
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_IN-1:0]  req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  pending,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;

  logic             accept_s;
  logic [N_IN-1:0]  clr_s;
  logic [N_IN-1:0]  cap_s;
  logic [N_IN-1:0]  pick_vec_s;
  logic [IDX_W-1:0] next_ptr_s;
  logic [IDX_W-1:0] pick_base_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_found_s;

  // In IDLE clr_s is zero, so the pick vector is simply the pending set;
  // on accept it excludes the index being retired (new requests are not seen).
  assign accept_s    = (state_q == PRESENT) && out_ready;
  assign clr_s       = accept_s ? onehot(out_idx_q) : '0;
  assign cap_s       = en ? req : '0;
  assign pending_d   = (pending_q & ~clr_s) | cap_s;
  assign overflow_d  = |(cap_s & pending_q & ~clr_s);
  assign pick_vec_s  = pending_q & ~clr_s;
  assign next_ptr_s  = (out_idx_q == IDX_W'(N_IN - 1)) ? '0 : (out_idx_q + IDX_W'(1));
  assign rr_ptr_d    = accept_s ? next_ptr_s : rr_ptr_q;
  assign pick_base_s = ROUND_ROBIN ? (accept_s ? next_ptr_s : rr_ptr_q) : '0;

  prio_pick #(
    .N (N_IN),
    .W (IDX_W)
  ) u_pick (
    .vec_i   (pick_vec_s),
    .base_i  (pick_base_s),
    .rot_i   (ROUND_ROBIN),
    .idx_o   (pick_idx_s),
    .found_o (pick_found_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      out_idx_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (|pending_q) ? PRESENT : IDLE;
      PRESENT: state_d = (accept_s && !pick_found_s) ? IDLE : PRESENT;
      default: state_d = IDLE;
    endcase
  end

  // Presented index: loaded on entry to PRESENT and on each accept, else held.
  always_comb begin
    out_idx_d = out_idx_q;
    case (state_q)
      IDLE:    out_idx_d = pick_found_s ? pick_idx_s : out_idx_q;
      PRESENT: out_idx_d = (accept_s && pick_found_s) ? pick_idx_s : out_idx_q;
      default: out_idx_d = out_idx_q;
    endcase
  end

  assign out_idx   = out_idx_q;
  assign out_valid = (state_q == PRESENT);
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Scoreboard bench for irq_priority_encoder: a fixed-priority and a
// round-robin instance, expected index streams checked at each handshake.
module tb_irq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_f, rdy_f, en_r, rdy_r;
  logic [7:0] req_f, req_r;
  logic [2:0] idx_f, idx_r;
  logic       vld_f, vld_r, ovf_f, ovf_r;
  logic [7:0] pend_f, pend_r;

  int checks = 0;
  int errors = 0;
  int exp_f[$];
  int exp_r[$];

  always #5 clk = ~clk;

  irq_priority_encoder #(.ROUND_ROBIN(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .en(en_f), .req(req_f),
    .out_idx(idx_f), .out_valid(vld_f), .out_ready(rdy_f),
    .pending(pend_f), .overflow(ovf_f)
  );

  irq_priority_encoder #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .en(en_r), .req(req_r),
    .out_idx(idx_r), .out_valid(vld_r), .out_ready(rdy_r),
    .pending(pend_r), .overflow(ovf_r)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted handshake must match the head of its queue.
  always @(negedge clk) begin
    if (!rst && vld_f && rdy_f) begin
      if (exp_f.size() == 0) check("fx_unexpected_accept", int'(idx_f), -1);
      else check("fx_sb_idx", int'(idx_f), exp_f.pop_front());
    end
    if (!rst && vld_r && rdy_r) begin
      if (exp_r.size() == 0) check("rr_unexpected_accept", int'(idx_r), -1);
      else check("rr_sb_idx", int'(idx_r), exp_r.pop_front());
    end
  end

  initial begin
    rst = 1'b1; en_f = 1'b1; en_r = 1'b1; rdy_f = 1'b0; rdy_r = 1'b0;
    req_f = 8'h00; req_r = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", int'(vld_f), 0);
    check("rst_idx", int'(idx_f), 0);
    check("rst_pending", int'(pend_f), 0);
    check("rst_overflow", int'(ovf_f), 0);

    // Single request, consumer always ready.
    rdy_f = 1'b1; req_f = 8'b0010_0000; exp_f.push_back(5);
    tick(); req_f = 8'h00;
    check("single_pend_c1", int'(pend_f), 8'h20);
    check("single_vld_c1", int'(vld_f), 0);
    tick();
    check("single_vld_c2", int'(vld_f), 1);
    check("single_idx_c2", int'(idx_f), 5);
    tick();
    check("single_vld_c3", int'(vld_f), 0);
    check("single_pend_c3", int'(pend_f), 0);

    // Fixed-priority burst with a 3-cycle stall.
    rdy_f = 1'b0; req_f = 8'b1000_1010;
    exp_f.push_back(1); exp_f.push_back(3); exp_f.push_back(7);
    tick(); req_f = 8'h00;
    check("burst_pend", int'(pend_f), 8'h8A);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("burst_stall_vld", int'(vld_f), 1);
      check("burst_stall_idx", int'(idx_f), 1);
    end
    rdy_f = 1'b1;
    check("burst_idx_a", int'(idx_f), 1);
    tick(); check("burst_idx_b", int'(idx_f), 3);
    tick(); check("burst_idx_c", int'(idx_f), 7);
    check("burst_vld_c", int'(vld_f), 1);
    tick();
    check("burst_vld_end", int'(vld_f), 0);
    check("burst_pend_end", int'(pend_f), 0);

    // Overflow: req[4] twice before acceptance, presented once.
    rdy_f = 1'b0; req_f = 8'h10;
    tick(); req_f = 8'h00;
    check("ovf_none_first", int'(ovf_f), 0);
    tick();
    check("ovf_presented", int'(idx_f), 4);
    req_f = 8'h10;
    tick(); req_f = 8'h00;
    check("ovf_pulse", int'(ovf_f), 1);
    tick();
    check("ovf_one_cycle", int'(ovf_f), 0);
    rdy_f = 1'b1; exp_f.push_back(4);
    tick();
    check("ovf_once_vld", int'(vld_f), 0);
    check("ovf_once_pend", int'(pend_f), 0);

    // Enable low: requests ignored.
    en_f = 1'b0; req_f = 8'hFF;
    tick(); req_f = 8'h00; en_f = 1'b1;
    check("en0_pend", int'(pend_f), 0);
    tick();
    check("en0_vld", int'(vld_f), 0);

    // Async reset while stalled on idx 6 with bit 0 also pending.
    rdy_f = 1'b0; req_f = 8'h40;
    tick(); req_f = 8'h00;
    tick();
    check("hold_idx6", int'(idx_f), 6);
    req_f = 8'h01;
    tick(); req_f = 8'h00;
    check("hold_pend", int'(pend_f), 8'h41);
    check("hold_idx_stable", int'(idx_f), 6);
    check("hold_vld_stable", int'(vld_f), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", int'(vld_f), 0);
    check("arst_idx", int'(idx_f), 0);
    check("arst_pend", int'(pend_f), 0);
    check("arst_ovf", int'(ovf_f), 0);
    #2 rst = 1'b0;
    rdy_f = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_vld", int'(vld_f), 0);
    end

    // Round-robin: 0, 2, 0 with req[0] re-pulsed during accept of 0.
    rdy_r = 1'b1; req_r = 8'b0000_0101;
    exp_r.push_back(0); exp_r.push_back(2); exp_r.push_back(0);
    tick(); req_r = 8'h00;
    tick();
    check("rr_idx0", int'(idx_r), 0);
    req_r = 8'h01;
    tick(); req_r = 8'h00;
    check("rr_idx2", int'(idx_r), 2);
    check("rr_no_ovf_a", int'(ovf_r), 0);
    tick();
    check("rr_idx0_again", int'(idx_r), 0);
    check("rr_no_ovf_b", int'(ovf_r), 0);
    tick();
    check("rr_idle", int'(vld_r), 0);

    // Pointer now at 1: bits 0 and 1 resolve as 1 then 0.
    req_r = 8'h03; exp_r.push_back(1); exp_r.push_back(0);
    tick(); req_r = 8'h00;
    tick();
    check("rr_rot_first", int'(idx_r), 1);
    tick();
    check("rr_rot_second", int'(idx_r), 0);
    tick();
    check("rr_rot_idle", int'(vld_r), 0);

    tick();
    check("fx_queue_empty", exp_f.size(), 0);
    check("rr_queue_empty", exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_priority_encoder.md
# irq_priority_encoder

Sequential 8-to-3 priority encoder: the return path for our one-hot decoders. It turns one-hot or multi-hot request pulses into a binary index stream. Requests are latched into a pending register. The block then presents one winning index at a time over a valid/ready handshake and clears each bit as it is accepted. It sits between event sources (interrupt lines, decoder-driven select lines) and any consumer that wants a compact index.

## Interface
- N_IN, 8: number of request lines.
- IDX_W, $clog2(N_IN) = 3: index width.
- ROUND_ROBIN, 0: 0 = fixed priority (lowest index wins); 1 = rotating priority.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  active-high capture enable for req.
- req  in  N_IN  request pulses, sampled each cycle.
- out_idx  out  IDX_W  presented winning index.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- pending  out  N_IN  latched, not-yet-accepted requests, including the presented one.
- overflow  out  1  one-cycle pulse when a request hits an already pending bit.

## Operation
- Capture: when en=1, pending |= req each cycle. When en=0, req is ignored; pending still drains.
- FSM states: IDLE (out_valid=0) and PRESENT (out_valid=1).
- IDLE -> PRESENT when pending != 0. On that edge, out_idx loads the pick from the current pending value.
- PRESENT with !out_ready: hold. out_idx and out_valid stay stable, even if a higher-priority request arrives.
- PRESENT with accept: clear pending[out_idx].
  - If (pending & ~onehot(out_idx)) != 0, stay in PRESENT and load the next pick from that masked value.
  - Otherwise go to IDLE.
- Back-to-back throughput is one index per cycle.
- Requests arriving in the accept cycle are not considered for that cycle's pick.
- Pick, fixed priority: lowest set index.
- Pick, round-robin: first set bit at or above rr_ptr, wrapping from N_IN-1 to 0.
  - rr_ptr <= (accepted idx + 1) mod N_IN, updated on accept only.
- Same-bit set and clear in one cycle (req[i] during accept of i): set wins, so pending[i] stays 1 and i is re-presented later. No overflow.
- overflow is registered. It pulses the cycle after req[i] & en & pending[i] & ~(accept & out_idx==i), for any i.
- Reset mid-operation: everything returns to reset values immediately. In-flight and pending requests are lost.

## Timing
- Reset values: pending=0, out_valid=0, out_idx=0, overflow=0, rr_ptr=0, FSM=IDLE.
- Latency, req to out_valid in IDLE: req sampled at edge k sets pending at edge k. Reading that as "req high in cycle 0, pending visible in cycle 1":
  - out_valid rises in cycle 2 (two edges).
- Accept-to-next-index latency: 0 extra cycles, because the next index is valid in the cycle after accept.
- All outputs are registered. No combinational path from req or out_ready to any output.

## Structure
- Shared package irq_enc_pkg holds:
  - N_IN_DEFAULT;
  - the IDX_W derivation;
  - the FSM state enum {IDLE, PRESENT};
  - the onehot(idx) function.
- Sub-module prio_pick (combinational):
  - inputs: vector, base pointer, rotate enable;
  - outputs: idx and found.
  - It is instantiated once. Fixed mode ties base=0.

## Test plan
- Reset then single request: req=8'b0010_0000 for 1 cycle, out_ready=1 -> out_idx=5, out_valid=1 for exactly one cycle in cycle 2; pending returns to 0.
- Fixed-priority burst:
  - Stimulus: req=8'b1000_1010 in one cycle; out_ready held 0 for 3 cycles, then 1.
  - Response: out_idx=1 stable while stalled, then 1, 3, 7 on consecutive cycles; out_valid drops after 7.
- Round-robin (ROUND_ROBIN=1):
  - Stimulus: pending=8'b0000_0101 with rr_ptr=0; req[0] re-pulsed during accept of 0.
  - Response: order is 0, 2, 0; no overflow.
- Overflow and enable:
  - req[4] pulsed twice before acceptance -> overflow pulses once and index 4 is presented once.
  - With en=0, req=8'hFF -> pending unchanged, no output.
- Async reset mid-stall: out_valid=1 with out_idx=6 and pending=8'b0100_0001; assert rst between edges -> all outputs 0 immediately; after release, no output without new req.
